// File: rtl/nios_practica_led_pwm.sv
// Avalon-MM LED output peripheral: 4 channels, each a static level or an 8-bit PWM with shared prescaler.
// Latency: register write lands at the sampling edge; out_port and readdata are registered (1 cycle later).
// Backpressure: none; every bus write is accepted in the cycle it is presented, no wait states.
//
// Ports:
//   clk, reset_n            - system clock, asynchronous active-low reset
//   address[2:0]            - register word address (0 DATA, 1 MODE, 2 PRESCALE, 3 PWMCNT, 4-7 DUTY0..3)
//   chipselect, write_n     - write happens when chipselect=1 and write_n=0
//   writedata[31:0]         - write data, bits above each register width ignored
//   readdata[31:0]          - registered read data for the address of the previous cycle
//   out_port[3:0]           - registered LED drive, 1 = LED on
module nios_practica_led_pwm #(
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  out_port
);

  // Register word addresses
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_PWMCNT   = 3'd3;
  localparam logic [2:0] ADDR_DUTY0    = 3'd4;
  localparam logic [2:0] ADDR_DUTY1    = 3'd5;
  localparam logic [2:0] ADDR_DUTY2    = 3'd6;
  localparam logic [2:0] ADDR_DUTY3    = 3'd7;

  // --------------------------------------------------------------------------
  // Bus write decode
  // --------------------------------------------------------------------------
  logic       wr_en;
  logic       data_we;
  logic       mode_we;
  logic       presc_we;
  logic [3:0] duty_we;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    data_we  = 1'b0;
    mode_we  = 1'b0;
    presc_we = 1'b0;
    duty_we  = 4'b0000;
    if (wr_en) begin
      unique case (address)
        ADDR_DATA:     data_we    = 1'b1;
        ADDR_MODE:     mode_we    = 1'b1;
        ADDR_PRESCALE: presc_we   = 1'b1;
        ADDR_PWMCNT:   ;  // read-only counter, writes dropped
        ADDR_DUTY0:    duty_we[0] = 1'b1;
        ADDR_DUTY1:    duty_we[1] = 1'b1;
        ADDR_DUTY2:    duty_we[2] = 1'b1;
        ADDR_DUTY3:    duty_we[3] = 1'b1;
        default:       ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Software-visible registers
  // --------------------------------------------------------------------------
  logic [3:0]       data_q,     data_d;
  logic [3:0]       mode_q,     mode_d;
  logic [15:0]      prescale_q, prescale_d;
  logic [3:0][7:0]  duty_q,     duty_d;

  always_comb begin
    data_d     = data_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (data_we)  data_d     = writedata[3:0];
    if (mode_we)  mode_d     = writedata[3:0];
    if (presc_we) prescale_d = writedata[15:0];
    for (int i = 0; i < 4; i++) begin
      if (duty_we[i]) duty_d[i] = writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= 4'd0;
      mode_q     <= 4'd0;
      prescale_q <= PRESCALE_RESET;
      duty_q     <= '0;
    end else begin
      data_q     <= data_d;
      mode_q     <= mode_d;
      prescale_q <= prescale_d;
      duty_q     <= duty_d;
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler and PWM counter
  // --------------------------------------------------------------------------
  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic        tick;

  // The tick is judged against the PRESCALE value in force this cycle, so a
  // PRESCALE write landing on a tick cycle still advances pwm_cnt; the write
  // only restarts the prescaler phase.
  assign tick = (pre_cnt_q == prescale_q);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 16'd1;
    if (presc_we || tick) pre_cnt_d = 16'd0;
    pwm_cnt_d = pwm_cnt_q;
    if (tick) pwm_cnt_d = pwm_cnt_q + 8'd1;  // natural 255 -> 0 wrap
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= 16'd0;
      pwm_cnt_q <= 8'd0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // LED drive: built from the current register state, so a DATA/MODE/DUTY
  // change shows up on the pins one edge after it is written, mid-period.
  // --------------------------------------------------------------------------
  logic [3:0] out_q, out_d;

  always_comb begin
    out_d = 4'd0;
    for (int i = 0; i < 4; i++) begin
      out_d[i] = mode_q[i] ? (duty_q[i] > pwm_cnt_q) : data_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= 4'd0;
    else          out_q <= out_d;
  end

  assign out_port = out_q;

  // --------------------------------------------------------------------------
  // Read path: no read strobe, readdata reloads every edge from the address
  // presented in the cycle before it. A write and a read of the same address
  // in one cycle returns the old value.
  // --------------------------------------------------------------------------
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = 32'd0;
    unique case (address)
      ADDR_DATA:     rdata_d = {28'd0, data_q};
      ADDR_MODE:     rdata_d = {28'd0, mode_q};
      ADDR_PRESCALE: rdata_d = {16'd0, prescale_q};
      ADDR_PWMCNT:   rdata_d = {24'd0, pwm_cnt_q};
      ADDR_DUTY0:    rdata_d = {24'd0, duty_q[0]};
      ADDR_DUTY1:    rdata_d = {24'd0, duty_q[1]};
      ADDR_DUTY2:    rdata_d = {24'd0, duty_q[2]};
      ADDR_DUTY3:    rdata_d = {24'd0, duty_q[3]};
      default:       rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= 32'd0;
    else          rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_nios_practica_led_pwm.sv
`timescale 1ns/1ps
// Bench for the LED PWM peripheral: register table, latency sequences, PWM duty counts,
// prescaler spacing, mixed modes and asynchronous reset.
// All bus activity is driven 1 ns after a rising edge and sampled 1 ns after the next one.
module tb_nios_practica_led_pwm;

  localparam logic [15:0] PRESC_RST = 16'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int checks = 0;
  int failures = 0;

  nios_practica_led_pwm #(.PRESCALE_RESET(PRESC_RST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: expected readdata for the bus cycle just driven
  typedef struct {
    logic        chk;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Table vector: one bus cycle plus the expected readdata it produces
  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle; expectation is queued at drive time and compared once the
  // registered readdata for that cycle appears.
  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string name);
    sb_t e;
    sb_t r;
    address    = a;
    chipselect = we;
    write_n    = ~we;
    writedata  = d;
    e.chk = chk;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    r = sb_q.pop_front();
    if (r.chk) check(name, readdata, r.exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus(1'b0, a, 32'd0, 1'b1, exp, name);
  endtask

  task automatic idle(input logic [2:0] a);
    bus(1'b0, a, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  // Count high cycles per LED over 256 consecutive clocks
  task automatic measure(output int c0, output int c1, output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int n = 0; n < 256; n++) begin
      idle(3'd3);
      if (out_port[0]) c0++;
      if (out_port[1]) c1++;
      if (out_port[2]) c2++;
      if (out_port[3]) c3++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [27];
    int c0, c1, c2, c3;
    int changes, bad_inc, bad_space, wrap_seen, t1, period, last_t;
    logic [7:0] prev, cur, v1, v;
    bit found;

    vt[0]  = '{1'b0, 3'd0, 32'h0,        1'b1, 32'h0};
    vt[1]  = '{1'b0, 3'd1, 32'h0,        1'b1, 32'h0};
    vt[2]  = '{1'b0, 3'd2, 32'h0,        1'b1, {16'd0, PRESC_RST}};
    vt[3]  = '{1'b0, 3'd4, 32'h0,        1'b1, 32'h0};
    vt[4]  = '{1'b0, 3'd5, 32'h0,        1'b1, 32'h0};
    vt[5]  = '{1'b0, 3'd6, 32'h0,        1'b1, 32'h0};
    vt[6]  = '{1'b0, 3'd7, 32'h0,        1'b1, 32'h0};
    vt[7]  = '{1'b1, 3'd0, 32'hFFFFFFF5, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 3'd0, 32'h0,        1'b1, 32'h5};
    vt[9]  = '{1'b1, 3'd4, 32'h000001AB, 1'b0, 32'h0};
    vt[10] = '{1'b1, 3'd5, 32'hFFFFFFCD, 1'b0, 32'h0};
    vt[11] = '{1'b1, 3'd6, 32'h00000012, 1'b0, 32'h0};
    vt[12] = '{1'b1, 3'd7, 32'h00000134, 1'b0, 32'h0};
    vt[13] = '{1'b0, 3'd4, 32'h0,        1'b1, 32'hAB};
    vt[14] = '{1'b0, 3'd5, 32'h0,        1'b1, 32'hCD};
    vt[15] = '{1'b0, 3'd6, 32'h0,        1'b1, 32'h12};
    vt[16] = '{1'b0, 3'd7, 32'h0,        1'b1, 32'h34};
    vt[17] = '{1'b1, 3'd1, 32'h000000F3, 1'b0, 32'h0};
    vt[18] = '{1'b0, 3'd1, 32'h0,        1'b1, 32'h3};
    vt[19] = '{1'b1, 3'd3, 32'h000000FF, 1'b0, 32'h0};
    vt[20] = '{1'b1, 3'd2, 32'hABCD1234, 1'b0, 32'h0};
    vt[21] = '{1'b0, 3'd2, 32'h0,        1'b1, 32'h1234};
    vt[22] = '{1'b0, 3'd0, 32'h0,        1'b1, 32'h5};
    vt[23] = '{1'b0, 3'd1, 32'h0,        1'b1, 32'h3};
    vt[24] = '{1'b0, 3'd4, 32'h0,        1'b1, 32'hAB};
    vt[25] = '{1'b1, 3'd0, 32'h0,        1'b0, 32'h0};
    vt[26] = '{1'b1, 3'd1, 32'h0,        1'b0, 32'h0};

    // ---------------- reset held with random bus activity ----------------
    for (int n = 0; n < 6; n++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      @(posedge clk);
      #1;
      check("rst_out_port", {28'd0, out_port}, 32'h0);
      check("rst_readdata", readdata, 32'h0);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    #3 reset_n = 1'b1;

    // ---------------- register table ----------------
    for (int i = 0; i < 27; i++) begin
      bus(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].chk, vt[i].exp, $sformatf("vec%0d", i));
    end

    // ---------------- static mode latency ----------------
    wr(3'd0, 32'hA);
    check("static_write_edge", {28'd0, out_port}, 32'h0);
    idle(3'd0);
    check("static_next_edge", {28'd0, out_port}, 32'hA);
    wr(3'd0, 32'hFFFFFFF5);
    rd(3'd0, 32'h5, "static_trunc_rd");
    check("static_trunc_out", {28'd0, out_port}, 32'h5);

    // ---------------- PWM duty with PRESCALE=0 ----------------
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h1);
    wr(3'd4, 32'd64);
    idle(3'd3);
    measure(c0, c1, c2, c3);
    check("duty64_high", c0, 64);
    wr(3'd4, 32'd0);
    idle(3'd3);
    measure(c0, c1, c2, c3);
    check("duty0_high", c0, 0);
    wr(3'd4, 32'd255);
    idle(3'd3);
    measure(c0, c1, c2, c3);
    check("duty255_high", c0, 255);

    // ---------------- prescaler = 3 ----------------
    wr(3'd2, 32'd3);
    idle(3'd3);
    prev = readdata[7:0];
    changes = 0; bad_inc = 0; bad_space = 0; wrap_seen = 0;
    t1 = -1; period = 0; last_t = -1; v1 = 8'd0;
    for (int c = 1; c <= 1200; c++) begin
      idle(3'd3);
      cur = readdata[7:0];
      if (cur != prev) begin
        changes++;
        if (cur != prev + 8'd1) bad_inc++;
        if (last_t >= 0 && (c - last_t) != 4) bad_space++;
        if (prev == 8'd255 && cur == 8'd0) wrap_seen = 1;
        if (t1 < 0) begin
          t1 = c;
          v1 = cur;
        end else if (cur == v1 && period == 0) begin
          period = c - t1;
        end
        last_t = c;
      end
      prev = cur;
    end
    check("presc_first_step", t1, 4);
    check("presc_changes", changes, 300);
    check("presc_bad_inc", bad_inc, 0);
    check("presc_bad_space", bad_space, 0);
    check("presc_wrap_seen", wrap_seen, 1);
    check("presc_period", period, 1024);

    // PRESCALE rewrite off a tick: spacing restarts from the write edge
    v = readdata[7:0];
    wr(3'd2, 32'd3);
    for (int n = 1; n <= 4; n++) begin
      idle(3'd3);
      check($sformatf("restart_hold%0d", n), readdata, {24'd0, v});
    end
    idle(3'd3);
    check("restart_step", readdata, {24'd0, v + 8'd1});

    // PRESCALE rewrite on a tick cycle: that tick still counts
    prev = readdata[7:0];
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      idle(3'd3);
      if (readdata[7:0] != prev) found = 1'b1;
    end
    check("tick_align_found", {31'd0, found}, 32'd1);
    v = readdata[7:0];
    idle(3'd3);
    idle(3'd3);
    wr(3'd2, 32'd3);
    for (int n = 1; n <= 4; n++) begin
      idle(3'd3);
      check($sformatf("coincide_hold%0d", n), readdata, {24'd0, v + 8'd1});
    end
    idle(3'd3);
    check("coincide_step", readdata, {24'd0, v + 8'd2});

    // ---------------- mixed modes ----------------
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h6);
    wr(3'd0, 32'h9);
    wr(3'd5, 32'd128);
    wr(3'd6, 32'd0);
    idle(3'd3);
    measure(c0, c1, c2, c3);
    check("mixed_led0", c0, 256);
    check("mixed_led1", c1, 128);
    check("mixed_led2", c2, 0);
    check("mixed_led3", c3, 256);

    // ---------------- reset mid-PWM ----------------
    wr(3'd1, 32'hF);
    wr(3'd4, 32'd255);
    wr(3'd5, 32'd255);
    wr(3'd6, 32'd255);
    wr(3'd7, 32'd255);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      idle(3'd3);
      if (readdata[7:0] == 8'd99) found = 1'b1;
    end
    check("pwm100_found", {31'd0, found}, 32'd1);
    check("pre_reset_out", {28'd0, out_port}, 32'hF);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_out", {28'd0, out_port}, 32'h0);
    check("async_rst_rd", readdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    rd(3'd3, 32'h0, "post_rst_pwmcnt");
    rd(3'd2, {16'd0, PRESC_RST}, "post_rst_presc");
    rd(3'd1, 32'h0, "post_rst_mode");
    rd(3'd4, 32'h0, "post_rst_duty0");
    check("post_rst_out", {28'd0, out_port}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
